// File: rtl/mc_controller.sv
// Multi-cycle control FSM for an RV32I core: sequences FETCH/DECODE/EXEC/MEM/WB over a
// shared datapath, counts retired instructions and halts on illegal opcodes or memory timeouts.
module mc_controller #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode_i,
  input  logic             br_taken_i,
  input  logic             imem_ack_i,
  input  logic             dmem_ack_i,
  output logic             imem_req_o,
  output logic             dmem_req_o,
  output logic             dmem_we_o,
  output logic             ir_we_o,
  output logic             pc_we_o,
  output logic [1:0]       pc_sel_o,
  output logic [1:0]       alu_a_sel_o,
  output logic             alu_b_sel_o,
  output logic [1:0]       alu_op_o,
  output logic             rf_we_o,
  output logic [1:0]       wb_sel_o,
  output logic [CNT_W-1:0] instret_o,
  output logic             halt_o,
  output logic [1:0]       cause_o
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_e;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [1:0] CAUSE_NONE = 2'd0;
  localparam logic [1:0] CAUSE_ILL  = 2'd1;
  localparam logic [1:0] CAUSE_IMEM = 2'd2;
  localparam logic [1:0] CAUSE_DMEM = 2'd3;

  // 17 bits holds any MEM_TIMEOUT up to 65535 plus the comparison headroom.
  localparam int TMO_W = 17;

  state_e             state_q, state_d;
  logic [TMO_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         cause_q, cause_d;
  logic [CNT_W-1:0]   instret_q, instret_d;

  logic [TMO_W-1:0]   cnt_inc;
  logic               timed_out;
  logic               is_legal;
  logic               is_mem_op;
  logic [1:0]         alu_a_dec;
  logic               alu_b_dec;
  logic [1:0]         alu_op_dec;

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned,
    // which would otherwise infer a latch.
    is_legal   = 1'b0;
    alu_a_dec  = 2'd0;
    alu_b_dec  = 1'b0;
    alu_op_dec = 2'd0;
    case (opcode_i)
      OPC_OP:     begin is_legal = 1'b1; alu_op_dec = 2'd1; end
      OPC_OP_IMM: begin is_legal = 1'b1; alu_b_dec = 1'b1; alu_op_dec = 2'd2; end
      OPC_LUI:    begin is_legal = 1'b1; alu_a_dec = 2'd2; alu_b_dec = 1'b1; end
      OPC_AUIPC:  begin is_legal = 1'b1; alu_a_dec = 2'd1; alu_b_dec = 1'b1; end
      OPC_LOAD,
      OPC_STORE:  begin is_legal = 1'b1; alu_b_dec = 1'b1; end
      OPC_BRANCH,
      OPC_JAL,
      OPC_JALR:   is_legal = 1'b1;
      default:    is_legal = 1'b0;
    endcase
  end

  assign is_mem_op = (opcode_i == OPC_LOAD) || (opcode_i == OPC_STORE);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      cnt_q     <= '0;
      cause_q   <= CAUSE_NONE;
      instret_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cause_q   <= cause_d;
      instret_q <= instret_d;
    end
  end

  // Next-state logic; the timeout counter only runs while a request waits for ack.
  always_comb begin
    state_d   = state_q;
    cnt_d     = '0;
    cause_d   = cause_q;
    cnt_inc   = cnt_q + TMO_W'(1);
    timed_out = (cnt_inc == TMO_W'(MEM_TIMEOUT));
    case (state_q)
      S_FETCH: begin
        if (imem_ack_i) begin
          state_d = S_DECODE;
        end else if (timed_out) begin
          state_d = S_TRAP;
          cause_d = CAUSE_IMEM;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_DECODE: begin
        if (is_legal) begin
          state_d = S_EXEC;
        end else begin
          state_d = S_TRAP;
          cause_d = CAUSE_ILL;
        end
      end
      S_EXEC: begin
        if (opcode_i == OPC_BRANCH) state_d = S_FETCH;
        else if (is_mem_op)         state_d = S_MEM;
        else                        state_d = S_WB;
      end
      S_MEM: begin
        if (dmem_ack_i) begin
          state_d = (opcode_i == OPC_STORE) ? S_FETCH : S_WB;
        end else if (timed_out) begin
          state_d = S_TRAP;
          cause_d = CAUSE_DMEM;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_WB:    state_d = S_FETCH;
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
  end

  // Moore output decode; rst forces everything low in the same cycle to abort in-flight requests.
  always_comb begin
    imem_req_o  = 1'b0;
    dmem_req_o  = 1'b0;
    dmem_we_o   = 1'b0;
    ir_we_o     = 1'b0;
    pc_we_o     = 1'b0;
    pc_sel_o    = 2'd0;
    alu_a_sel_o = 2'd0;
    alu_b_sel_o = 1'b0;
    alu_op_o    = 2'd0;
    rf_we_o     = 1'b0;
    wb_sel_o    = 2'd0;
    halt_o      = 1'b0;
    cause_o     = CAUSE_NONE;
    instret_o   = '0;
    if (!rst) begin
      cause_o   = cause_q;
      instret_o = instret_q;
      case (state_q)
        S_FETCH: begin
          imem_req_o = 1'b1;
          ir_we_o    = imem_ack_i;
        end
        S_EXEC: begin
          alu_a_sel_o = alu_a_dec;
          alu_b_sel_o = alu_b_dec;
          alu_op_o    = alu_op_dec;
          if (opcode_i == OPC_BRANCH) begin
            pc_we_o  = 1'b1;
            pc_sel_o = br_taken_i ? 2'd1 : 2'd0;
          end
        end
        S_MEM: begin
          dmem_req_o  = 1'b1;
          dmem_we_o   = (opcode_i == OPC_STORE);
          alu_a_sel_o = alu_a_dec;
          alu_b_sel_o = alu_b_dec;
          alu_op_o    = alu_op_dec;
          pc_we_o     = dmem_ack_i && (opcode_i == OPC_STORE);
        end
        S_WB: begin
          // ALU selects stay on so a combinational ALU result is still valid at the rd write.
          alu_a_sel_o = alu_a_dec;
          alu_b_sel_o = alu_b_dec;
          alu_op_o    = alu_op_dec;
          rf_we_o     = 1'b1;
          pc_we_o     = 1'b1;
          if (opcode_i == OPC_LOAD)                               wb_sel_o = 2'd1;
          else if (opcode_i == OPC_JAL || opcode_i == OPC_JALR)   wb_sel_o = 2'd2;
          if (opcode_i == OPC_JAL)       pc_sel_o = 2'd1;
          else if (opcode_i == OPC_JALR) pc_sel_o = 2'd2;
        end
        S_TRAP:  halt_o = 1'b1;
        default: ;
      endcase
    end
  end

  // Every pc_we_o pulse is a retirement; TRAP never drives pc_we_o.
  always_comb begin
    instret_d = instret_q + CNT_W'(pc_we_o);
  end

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: walks each instruction class, the timeout paths and
// mid-operation reset, comparing the packed control vector against hand-derived values.
module tb_mc_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  opcode;
  logic        br_taken, imem_ack, dmem_ack;
  logic        imem_req, dmem_req, dmem_we, ir_we, pc_we, alu_b_sel, rf_we, halt;
  logic [1:0]  pc_sel, alu_a_sel, alu_op, wb_sel, cause;
  logic [31:0] instret;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_instret = 0;
  logic [17:0] e;

  localparam logic [31:0] I_ADDI = 32'h00500093;
  localparam logic [31:0] I_BEQ  = 32'h00000463;
  localparam logic [31:0] I_LW   = 32'h00002103;
  localparam logic [31:0] I_SW   = 32'h00202023;
  localparam logic [31:0] I_JAL  = 32'h010000EF;
  localparam logic [31:0] I_JALR = 32'h000080E7;
  localparam logic [31:0] I_ILL  = 32'h0000007F;

  // Mask that ignores the ALU select fields where they carry no meaning.
  localparam logic [17:0] NO_ALU = 18'h3F83F;

  always #5 clk = ~clk;

  mc_controller #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .opcode_i(opcode), .br_taken_i(br_taken),
    .imem_ack_i(imem_ack), .dmem_ack_i(dmem_ack),
    .imem_req_o(imem_req), .dmem_req_o(dmem_req), .dmem_we_o(dmem_we),
    .ir_we_o(ir_we), .pc_we_o(pc_we), .pc_sel_o(pc_sel),
    .alu_a_sel_o(alu_a_sel), .alu_b_sel_o(alu_b_sel), .alu_op_o(alu_op),
    .rf_we_o(rf_we), .wb_sel_o(wb_sel), .instret_o(instret),
    .halt_o(halt), .cause_o(cause)
  );

  wire [17:0] ctl = {imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel,
                     alu_a_sel, alu_b_sel, alu_op, rf_we, wb_sel, halt, cause};

  function automatic logic [17:0] cv(input int imr, dmr, dwe, irw, pcw, pcs,
                                     input int as, bs, op, rfw, wbs, h, c);
    return {1'(imr), 1'(dmr), 1'(dwe), 1'(irw), 1'(pcw), 2'(pcs),
            2'(as), 1'(bs), 2'(op), 1'(rfw), 2'(wbs), 1'(h), 2'(c)};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b0; br_taken = 1'b0;
    tick();
    rst = 1'b0;
    exp_instret = 0;
  endtask

  // FETCH with ack in the current cycle, then the silent DECODE cycle.
  task automatic fetch(input logic [31:0] instr, input string nm);
    imem_ack = 1'b1; opcode = instr[6:0]; #1;
    e = cv(1,0,0,1,0,0, 0,0,0,0,0,0,0);
    checks++; if (ctl !== e) begin errors++; $display("FAIL %s_fetch: got %h want %h", nm, ctl, e); end
    tick();
    imem_ack = 1'b0; #1;
    checks++; if (ctl !== 18'h0) begin errors++; $display("FAIL %s_decode: got %h want 0", nm, ctl); end
    tick();
  endtask

  task automatic check_instret(input string nm);
    checks++;
    if (instret !== exp_instret) begin
      errors++; $display("FAIL %s_instret: got %0d want %0d", nm, instret, exp_instret);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b0; br_taken = 1'b0; opcode = 7'h0;
    tick(); tick(); #1;
    checks++; if (ctl !== 18'h0) begin errors++; $display("FAIL reset_ctl: got %h want 0", ctl); end
    check_instret("reset");
    rst = 1'b0; #1;
    e = cv(1,0,0,0,0,0, 0,0,0,0,0,0,0);
    checks++; if (ctl !== e) begin errors++; $display("FAIL reset_fetch: got %h want %h", ctl, e); end
    tick();
  endtask

  task automatic test_alu;
    fetch(I_ADDI, "addi"); #1;
    e = cv(0,0,0,0,0,0, 0,1,2,0,0,0,0);
    checks++; if (ctl !== e) begin errors++; $display("FAIL addi_exec: got %h want %h", ctl, e); end
    tick(); #1;
    e = cv(0,0,0,0,1,0, 0,0,0,1,0,0,0);
    checks++; if ((ctl & NO_ALU) !== e) begin errors++; $display("FAIL addi_wb: got %h want %h", ctl & NO_ALU, e); end
    tick();
    exp_instret++;
    check_instret("addi");
  endtask

  task automatic test_branch(input int taken);
    br_taken = 1'(taken);
    fetch(I_BEQ, "beq"); #1;
    e = cv(0,0,0,0,1,taken, 0,0,0,0,0,0,0);
    checks++; if ((ctl & NO_ALU) !== e) begin errors++; $display("FAIL beq_exec_t%0d: got %h want %h", taken, ctl & NO_ALU, e); end
    tick();
    br_taken = 1'b0;
    exp_instret++;
    check_instret("beq");
    e = cv(1,0,0,0,0,0, 0,0,0,0,0,0,0);
    checks++; if (ctl !== e) begin errors++; $display("FAIL beq_back_to_fetch: got %h want %h", ctl, e); end
  endtask

  task automatic test_load;
    fetch(I_LW, "lw"); #1;
    e = cv(0,0,0,0,0,0, 0,1,0,0,0,0,0);
    checks++; if (ctl !== e) begin errors++; $display("FAIL lw_exec: got %h want %h", ctl, e); end
    tick();
    for (int i = 0; i < 3; i++) begin
      dmem_ack = (i == 2); #1;
      e = cv(0,1,0,0,0,0, 0,1,0,0,0,0,0);
      checks++; if (ctl !== e) begin errors++; $display("FAIL lw_mem%0d: got %h want %h", i, ctl, e); end
      tick();
    end
    dmem_ack = 1'b0; #1;
    e = cv(0,0,0,0,1,0, 0,0,0,1,1,0,0);
    checks++; if ((ctl & NO_ALU) !== e) begin errors++; $display("FAIL lw_wb: got %h want %h", ctl & NO_ALU, e); end
    tick();
    exp_instret++;
    check_instret("lw");
  endtask

  task automatic test_store;
    fetch(I_SW, "sw"); #1;
    e = cv(0,0,0,0,0,0, 0,1,0,0,0,0,0);
    checks++; if (ctl !== e) begin errors++; $display("FAIL sw_exec: got %h want %h", ctl, e); end
    tick();
    dmem_ack = 1'b1; #1;
    e = cv(0,1,1,0,1,0, 0,1,0,0,0,0,0);
    checks++; if (ctl !== e) begin errors++; $display("FAIL sw_mem: got %h want %h", ctl, e); end
    tick();
    dmem_ack = 1'b0;
    exp_instret++;
    check_instret("sw");
  endtask

  task automatic test_jump(input logic [31:0] instr, input int pcs, input string nm);
    fetch(instr, nm); #1;
    checks++; if ((ctl & NO_ALU) !== 18'h0) begin errors++; $display("FAIL %s_exec: got %h want 0", nm, ctl & NO_ALU); end
    tick(); #1;
    e = cv(0,0,0,0,1,pcs, 0,0,0,1,2,0,0);
    checks++; if ((ctl & NO_ALU) !== e) begin errors++; $display("FAIL %s_wb: got %h want %h", nm, ctl & NO_ALU, e); end
    tick();
    exp_instret++;
    check_instret(nm);
  endtask

  task automatic test_reset_mid_mem;
    fetch(I_LW, "rstmem");
    tick(); #1;
    checks++; if (dmem_req !== 1'b1) begin errors++; $display("FAIL rstmem_req: got %b want 1", dmem_req); end
    tick();
    rst = 1'b1; #1;
    checks++; if (ctl !== 18'h0) begin errors++; $display("FAIL rstmem_drop: got %h want 0", ctl); end
    exp_instret = 0;
    check_instret("rstmem_now");
    tick(); #1;
    checks++; if (ctl !== 18'h0) begin errors++; $display("FAIL rstmem_held: got %h want 0", ctl); end
    rst = 1'b0; #1;
    e = cv(1,0,0,0,0,0, 0,0,0,0,0,0,0);
    checks++; if (ctl !== e) begin errors++; $display("FAIL rstmem_fetch: got %h want %h", ctl, e); end
  endtask

  // Ack arriving on the cycle the counter reaches MEM_TIMEOUT must win.
  task automatic test_ack_at_limit;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (imem_req !== 1'b1 || halt !== 1'b0) begin errors++; $display("FAIL limit_wait%0d: req=%b halt=%b want 1/0", i, imem_req, halt); end
      tick();
    end
    fetch(I_ADDI, "limit");
    tick(); tick();
    exp_instret++;
    check_instret("limit");
  endtask

  task automatic test_dmem_timeout;
    do_reset();
    fetch(I_LW, "dtmo");
    tick();
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (dmem_req !== 1'b1) begin errors++; $display("FAIL dtmo_wait%0d: got %b want 1", i, dmem_req); end
      tick();
    end
    #1;
    e = cv(0,0,0,0,0,0, 0,0,0,0,0,1,3);
    checks++; if (ctl !== e) begin errors++; $display("FAIL dtmo_trap: got %h want %h", ctl, e); end
    check_instret("dtmo");
  endtask

  task automatic test_illegal;
    do_reset();
    fetch(I_ILL, "ill"); #1;
    e = cv(0,0,0,0,0,0, 0,0,0,0,0,1,1);
    checks++; if (ctl !== e) begin errors++; $display("FAIL ill_trap: got %h want %h", ctl, e); end
    imem_ack = 1'b1; dmem_ack = 1'b1; #1;
    checks++; if (ctl !== e) begin errors++; $display("FAIL ill_acks: got %h want %h", ctl, e); end
    tick(); tick(); #1;
    checks++; if (ctl !== e) begin errors++; $display("FAIL ill_hold: got %h want %h", ctl, e); end
    check_instret("ill");
    rst = 1'b1; #1;
    checks++; if (ctl !== 18'h0) begin errors++; $display("FAIL ill_rst: got %h want 0", ctl); end
    imem_ack = 1'b0; dmem_ack = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_imem_timeout;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      #1;
      e = cv(1,0,0,0,0,0, 0,0,0,0,0,0,0);
      checks++; if (ctl !== e) begin errors++; $display("FAIL itmo_wait%0d: got %h want %h", i, ctl, e); end
      tick();
    end
    #1;
    e = cv(0,0,0,0,0,0, 0,0,0,0,0,1,2);
    checks++; if (ctl !== e) begin errors++; $display("FAIL itmo_trap: got %h want %h", ctl, e); end
    tick(); #1;
    checks++; if (ctl !== e) begin errors++; $display("FAIL itmo_hold: got %h want %h", ctl, e); end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_branch(1);
    test_branch(0);
    test_load();
    test_store();
    test_jump(I_JAL, 1, "jal");
    test_jump(I_JALR, 2, "jalr");
    test_reset_mid_mem();
    test_ack_at_limit();
    test_dmem_timeout();
    test_illegal();
    test_imem_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
